// File: rtl/bus_access_arbiter.sv
// bus_access_arbiter: round-robin arbiter sequencing one DLX async bus cycle (as_n/wr_n/ack_n) per grant for a read and a write requester
//   Ports: i_clk, i_reset (sync, active high), i_rd_req/i_wr_req (level-held requests), i_ack_n (bus ack, active low)
//          o_as_n/o_wr_n (bus strobes, active low), o_grant_wr (addr/data mux select, 1 = write), o_rd_data_ce (read data latch enable)
//          o_rd_done/o_wr_done (completion pulses), o_bus_err (timeout pulse), o_busy, o_bus_state (IDLE=0 ADDR=1 WAIT_ACK=2 DONE=3)
//   Option: define BUS_TIMEOUT_EN to terminate WAIT_ACK after TIMEOUT_CYC cycles without ack; otherwise it waits indefinitely
module bus_access_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rd_req,
  input  logic       i_wr_req,
  input  logic       i_ack_n,
  output logic       o_as_n,
  output logic       o_wr_n,
  output logic       o_grant_wr,
  output logic       o_rd_data_ce,
  output logic       o_rd_done,
  output logic       o_wr_done,
  output logic       o_bus_err,
  output logic       o_busy,
  output logic [1:0] o_bus_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT_ACK = 2'd2, DONE = 2'd3} state_t;
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_param
    $error("bus_access_arbiter: illegal TIMEOUT_CYC/CNT_W");
  end
  state_t r_state, w_next;
  logic   r_last_wr, w_pick_wr, w_grant, w_timeout, w_on_bus;
`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign w_timeout = r_state == WAIT_ACK && i_ack_n && r_cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign o_bus_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_bus_err = 1'b0;
`endif
  // read wins a tie unless the previous cycle was a read
  always_comb begin
    w_pick_wr = i_wr_req & (~i_rd_req | ~r_last_wr);
    w_grant   = r_state == IDLE ? w_pick_wr : o_grant_wr;
    w_next    = r_state == IDLE     ? ((i_rd_req | i_wr_req) ? ADDR : IDLE) :
                r_state == ADDR     ? WAIT_ACK :
                r_state == WAIT_ACK ? ((~i_ack_n | w_timeout) ? DONE : WAIT_ACK) : IDLE;
    w_on_bus  = w_next == ADDR || w_next == WAIT_ACK;
  end
  // strobes and done pulses are registered from the next state so they line up with r_state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      o_grant_wr <= 1'b0;
      r_last_wr  <= 1'b1;
      o_as_n     <= 1'b1;
      o_wr_n     <= 1'b1;
      o_rd_done  <= 1'b0;
      o_wr_done  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      o_as_n    <= ~w_on_bus;
      o_wr_n    <= ~(w_on_bus & w_grant);
      o_rd_done <= w_next == DONE && !w_grant;
      o_wr_done <= w_next == DONE && w_grant;
      if (r_state == IDLE && w_next == ADDR) o_grant_wr <= w_pick_wr;
      if (r_state == DONE) r_last_wr <= o_grant_wr;
`ifdef BUS_TIMEOUT_EN
      r_cnt     <= r_state == WAIT_ACK ? r_cnt + 1'b1 : '0;
      r_err     <= w_timeout;
`endif
    end
  end
  assign o_rd_data_ce = r_state == WAIT_ACK && !i_ack_n && !o_grant_wr;
  assign o_busy       = r_state != IDLE;
  assign o_bus_state  = r_state;
endmodule

// File: tb/tb_bus_access_arbiter.sv
// tb_bus_access_arbiter: random requesters and ack responder checked against a transaction-timing model and a done-event scoreboard
module tb_bus_access_arbiter;
  logic clk = 0, reset = 1, rd_req = 0, wr_req = 0, ack_n = 1;
  logic as_n, wr_n, grant_wr, rd_data_ce, rd_done, wr_done, bus_err, busy;
  logic [1:0] bus_state;
  int errors = 0, checks = 0;
  bus_access_arbiter #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_rd_req(rd_req), .i_wr_req(wr_req), .i_ack_n(ack_n),
    .o_as_n(as_n), .o_wr_n(wr_n), .o_grant_wr(grant_wr), .o_rd_data_ce(rd_data_ce),
    .o_rd_done(rd_done), .o_wr_done(wr_done), .o_bus_err(bus_err), .o_busy(busy), .o_bus_state(bus_state)
  );
  always #5 clk = ~clk;
  typedef struct {bit wr; int edge_n;} exp_t;
  exp_t q[$];
  int n, m_free, cg, cd;
  bit m_last_wr, cv, cw, run, gen;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, n);
    end
  endtask
  task automatic release_reset();
    @(posedge clk);
    #1 reset = 0;
    ack_n = 1;
    n = 0; m_free = 0; m_last_wr = 1; cv = 0;
    q.delete();
  endtask
  task automatic do_reset(input int c);
    reset = 1;
    repeat (c - 1) @(posedge clk);
    release_reset();
  endtask
  // one clock of the reference model: a bus cycle granted at edge g with ack delay d
  // occupies ADDR after g, WAIT_ACK after g+1..g+1+d, DONE after g+2+d, idle sampling again at g+4+d
  task automatic step();
    bit cleared_rd, cleared_wr;
    @(posedge clk);
    n++;
    if (n >= m_free && (rd_req || wr_req)) begin
      cw = wr_req && (!rd_req || !m_last_wr);
      cd = $urandom_range(0, 3);
      cg = n; cv = 1;
      q.push_back('{cw, n + 2 + cd});
      m_free = n + 4 + cd;
      m_last_wr = cw;
    end
    #1;
    ack_n = !(cv && n == cg + 1 + cd);
    if (ack_n && !(cv && n >= cg + 1 && n <= cg + cd) && $urandom_range(0, 3) == 0) ack_n = 0;
    cleared_rd = 0; cleared_wr = 0;
    if (cv && n == cg + 3 + cd) begin
      if (cw) begin wr_req = 0; cleared_wr = 1; end
      else begin rd_req = 0; cleared_rd = 1; end
    end
    if (gen && !rd_req && !cleared_rd && $urandom_range(0, 2) != 0) rd_req = 1;
    if (gen && !wr_req && !cleared_wr && $urandom_range(0, 2) != 0) wr_req = 1;
  endtask
  always @(negedge clk) begin
    if (run) begin
      bit ins, bsy;
      int st;
      ins = cv && n >= cg && n <= cg + 1 + cd;
      bsy = cv && n >= cg && n <= cg + 2 + cd;
      st = !bsy ? 0 : n == cg ? 1 : n == cg + 2 + cd ? 3 : 2;
      chk("as_n", as_n, !ins);
      chk("wr_n", wr_n, !(ins && cw));
      chk("rd_data_ce", rd_data_ce, cv && n == cg + 1 + cd && !cw);
      chk("busy", busy, bsy);
      chk("bus_state", bus_state, st);
      chk("bus_err", bus_err, 0);
      if (bsy) chk("grant_wr", grant_wr, cw);
      if (rd_done || wr_done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_wr", wr_done, e.wr);
          chk("done_rd", rd_done, !e.wr);
          chk("done_edge", n, e.edge_n);
        end
      end else if (q.size() != 0 && q[0].edge_n < n) begin
        chk("missing_done", 0, 1);
        void'(q.pop_front());
      end
    end
  end
  initial begin
    int waits, bad;
    bit ce_seen;
    run = 0; gen = 0;
    do_reset(2);
    @(negedge clk);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rd_ce", rd_data_ce, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_grant", grant_wr, 0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_as_n", as_n, 1);
      chk("idle_wr_n", wr_n, 1);
      chk("idle_busy", busy, 0);
      chk("idle_state", bus_state, 0);
      @(negedge clk);
    end
    // both requests pending from reset release, then random traffic
    rd_req = 1; wr_req = 1;
    do_reset(2);
    run = 1; gen = 1;
    repeat (800) step();
    gen = 0;
    repeat (12) step();
    run = 0;
    chk("drain1", q.size(), 0);
    // reset in WAIT_ACK of a write aborts the cycle without a done pulse
    rd_req = 0; wr_req = 1;
    do_reset(2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_state", bus_state, 2);
    chk("pre_abort_wr_n", wr_n, 0);
    reset = 1;
    @(negedge clk);
    chk("abort_as_n", as_n, 1);
    chk("abort_wr_n", wr_n, 1);
    chk("abort_state", bus_state, 0);
    chk("abort_wr_done", wr_done, 0);
    release_reset();
    run = 1;
    repeat (12) step();
    run = 0;
    chk("drain2", q.size(), 0);
    // read with ack_n never arriving
    rd_req = 1; wr_req = 0;
    do_reset(2);
    waits = 0; bad = 0; ce_seen = 0;
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 60 && bus_state != 3; i++) begin
      @(negedge clk);
      if (bus_state == 2) waits++;
      if (rd_data_ce) ce_seen = 1;
    end
    chk("to_reached_done", bus_state, 3);
    chk("to_wait_cycles", waits, 16);
    chk("to_bus_err", bus_err, 1);
    chk("to_rd_done", rd_done, 1);
    chk("to_rd_ce", ce_seen, 0);
`else
    repeat (2) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_state != 2) bad++;
      if (bus_err || rd_done || rd_data_ce) bad++;
    end
    chk("no_to_hold_wait", bad, 0);
    chk("no_to_state", bus_state, 2);
`endif
    rd_req = 0;
    do_reset(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_access_arbiter.md
Name: bus_access_arbiter

Overview:
- Shares the DLX external asynchronous bus (as_n / wr_n / ack_n) between a read requester (fetch/load path) and a write requester (store path).
- Sequences one complete bus cycle per grant.
- Applies round-robin priority when both requesters are pending.
- Sits between the read/write datapath controllers and the bus pins. Generates the address/data mux select, the read-data latch enable and per-requester completion strobes.

Parameters:
- TIMEOUT_CYC, 16: max WAIT_ACK cycles before forced termination (used only with BUS_TIMEOUT_EN; legal range 2..255).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  read requester pending; held high until rd_done.
- wr_req  in  1  write requester pending; held high until wr_done.
- ack_n  in  1  bus acknowledge, active low.
- as_n  out  1  address strobe, active low.
- wr_n  out  1  write strobe, active low.
- grant_wr  out  1  1 = write owns the bus (addr/data mux select); 0 = read.
- rd_data_ce  out  1  latch enable for read data register.
- rd_done  out  1  one-cycle completion pulse to read requester.
- wr_done  out  1  one-cycle completion pulse to write requester.
- bus_err  out  1  one-cycle pulse on timeout termination (tied 0 without BUS_TIMEOUT_EN).
- busy  out  1  high in any state other than IDLE.
- bus_state  out  2  current state encoding (debug/LEDs).

Behaviour:
- States (2-bit): IDLE=0, ADDR=1, WAIT_ACK=2, DONE=3. Undefined encodings go to IDLE.
- Reset (sampled at posedge):
  - state=IDLE, grant_wr=0, last_wr=1 (so read wins the first tie), timeout counter=0.
  - Outputs after reset: as_n=1, wr_n=1, rd_done=wr_done=rd_data_ce=bus_err=0, busy=0.
  - Reset mid-cycle aborts immediately: no done pulse, strobes return high at the same edge.
- IDLE:
  - Neither request: stay.
  - Only one request: grant it.
  - Both requests: grant the side opposite last_wr.
  - On a grant: register grant_wr, go to ADDR.
- ADDR (exactly 1 cycle): as_n=0; wr_n=~grant_wr. Next state is WAIT_ACK.
- WAIT_ACK: as_n=0; wr_n=~grant_wr; counter increments each cycle.
  - ack_n==0: go to DONE. rd_data_ce=1 combinationally in this cycle if grant_wr==0.
  - ack_n==1 for the full timeout: see Optional Feature.
- DONE (exactly 1 cycle):
  - as_n=1, wr_n=1.
  - rd_done=~grant_wr or wr_done=grant_wr; bus_err as flagged.
  - last_wr<=grant_wr; counter cleared; next state is IDLE.
- Strobes are Moore outputs decoded from state. grant_wr changes only on the IDLE->ADDR edge.
- Requester rule: a requester clears req at the same edge its done is high. Requests are sampled only in IDLE, so a requester just served cannot be re-granted spuriously.
- Minimum bus cycle is 4 clocks (IDLE->ADDR->WAIT_ACK->DONE) with ack in the first WAIT_ACK cycle. Back-to-back bus cycles have one IDLE cycle between them.
- Requests arriving outside IDLE wait; nothing is lost because req is level-held.
- ack_n low outside WAIT_ACK is ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - When the counter reaches TIMEOUT_CYC-1 in WAIT_ACK with ack_n still high, go to DONE.
  - The done pulse for the granted side is still issued, with bus_err=1 in that DONE cycle.
  - rd_data_ce stays 0 on a timeout.
- Undefined:
  - WAIT_ACK waits indefinitely for ack_n.
  - The counter logic is not synthesised; bus_err is constant 0.

Test Plan:
- reset held 2 cycles, then released with no requests -> as_n=wr_n=1, busy=0, bus_state=0 for 10 cycles.
- Single read: rd_req=1, ack_n low on the 3rd WAIT_ACK cycle -> as_n low 4 cycles, wr_n=1 throughout, rd_data_ce=1 in the ack cycle, rd_done pulse 1 cycle later, bus_state sequence 0,1,2,2,2,3,0.
- Both requests held from reset release, each dropped on its own done, ack_n=0 immediately -> read granted first, then write. wr_n low for exactly 2 cycles in the write cycle; one IDLE cycle between the two cycles.
- Continuous rd_req and wr_req, requester re-asserts one cycle after done -> grants alternate R,W,R,W over 8 cycles; no side is granted twice in a row.
- reset asserted in WAIT_ACK of a write -> at the next edge as_n=wr_n=1, bus_state=0, no wr_done; after release with wr_req still high, a new cycle runs and wr_done pulses once.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=16, ack_n held high -> DONE entered after 16 WAIT_ACK cycles, bus_err=1 with rd_done=1 in the same cycle, rd_data_ce never asserted. Without the macro, the same stimulus keeps bus_state=2 for 100 cycles.
